// File: rtl/cla_adder.sv
// Registered carry-lookahead adder: 4-bit CLA groups feeding a
// second-level lookahead unit; {carry_out,sum} captured each clock.
module cla_adder #(
  parameter int DATA_WID = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_WID-1:0] in1,
  input  logic [DATA_WID-1:0] in2,
  input  logic                carry_in,
  output logic [DATA_WID-1:0] sum,
  output logic                carry_out
);

  localparam int NGRP = DATA_WID / 4;

  logic [DATA_WID-1:0] w_g;
  logic [DATA_WID-1:0] w_p;
  logic [DATA_WID-1:0] w_c;
  logic [NGRP-1:0]     w_gg;
  logic [NGRP-1:0]     w_gp;
  logic [NGRP:0]       w_gx;
  logic [NGRP:0]       w_gc;

  assign w_g  = in1 & in2;
  assign w_p  = in1 ^ in2;
  assign w_gx = {w_gg, carry_in};

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    localparam int B = 4 * k;
    logic w_g0, w_g1, w_g2, w_g3;
    logic w_p0, w_p1, w_p2, w_p3;
    logic w_ci;

    assign {w_g3, w_g2, w_g1, w_g0} = w_g[B+3:B];
    assign {w_p3, w_p2, w_p1, w_p0} = w_p[B+3:B];
    assign w_ci = w_gc[k];

    assign w_gg[k] = w_g3
                   | (w_p3 & w_g2)
                   | (w_p3 & w_p2 & w_g1)
                   | (w_p3 & w_p2 & w_p1 & w_g0);
    assign w_gp[k] = w_p3 & w_p2 & w_p1 & w_p0;

    assign w_c[B]   = w_ci;
    assign w_c[B+1] = w_g0 | (w_p0 & w_ci);
    assign w_c[B+2] = w_g1
                    | (w_p1 & w_g0)
                    | (w_p1 & w_p0 & w_ci);
    assign w_c[B+3] = w_g2
                    | (w_p2 & w_g1)
                    | (w_p2 & w_p1 & w_g0)
                    | (w_p2 & w_p1 & w_p0 & w_ci);
  end

  // Each group carry is a flat sum of products over lower G/P and
  // carry_in, so no carry ripples from one group into the next.
  always_comb begin
    w_gc = '0;
    for (int k = 0; k <= NGRP; k++) begin
      for (int j = 0; j <= k; j++) begin
        logic t;
        t = (j == k) ? w_gx[k] : w_gx[j];
        for (int m = j; m < k; m++) begin
          t = t & w_gp[m];
        end
        w_gc[k] = w_gc[k] | t;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      sum       <= w_p ^ w_c;
      carry_out <= w_gc[NGRP];
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// Directed and random checks of the registered 16-bit CLA adder
// against hand-computed values and an arithmetic reference.
module tb_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        carry_in;
  logic [15:0] sum;
  logic        carry_out;

  int n_chk = 0;
  int n_err = 0;

  cla_adder #(.DATA_WID(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in1       (in1),
    .in2       (in2),
    .carry_in  (carry_in),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] es,
                       input logic ec);
    n_chk++;
    assert ({carry_out, sum} === {ec, es}) else begin
      n_err++;
      $error("FAIL %s: got sum=%h co=%b want sum=%h co=%b",
             tag, sum, carry_out, es, ec);
    end
  endtask

  task automatic add(input string tag,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic ci,
                     input logic [15:0] es,
                     input logic ec);
    @(negedge clk);
    rst = 1'b0; in1 = a; in2 = b; carry_in = ci;
    @(negedge clk);
    check(tag, es, ec);
  endtask

  logic [15:0] bb_a  [8];
  logic [15:0] bb_b  [8];
  logic        bb_ci [8];
  logic [15:0] bb_s  [8];
  logic        bb_co [8];

  initial begin
    bb_a = '{16'h0001, 16'h1234, 16'h8000, 16'h00FF,
             16'hAAAA, 16'h0F0F, 16'h1000, 16'hFFF0};
    bb_b = '{16'h0001, 16'h4321, 16'h8000, 16'h0001,
             16'h5555, 16'hF0F0, 16'h2000, 16'h0010};
    bb_ci = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    // Step 4 runs under reset, so its expected output is zero.
    bb_s = '{16'h0002, 16'h5555, 16'h0000, 16'h0100,
             16'h0000, 16'h0000, 16'h3001, 16'h0000};
    bb_co = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; in1 = 16'h1234; in2 = 16'h1111; carry_in = 1'b0;
    @(negedge clk);
    check("reset1", 16'h0000, 1'b0);
    @(negedge clk);
    check("reset2", 16'h0000, 1'b0);

    add("small1", 16'h000A, 16'h0000, 1'b0, 16'h000A, 1'b0);
    add("small2", 16'h0014, 16'h000A, 1'b0, 16'h001E, 1'b0);
    add("small3", 16'h0014, 16'h0014, 1'b0, 16'h0028, 1'b0);
    add("wide1",  16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
    add("wide2",  16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFE, 1'b1);
    add("wide3",  16'hBFFF, 16'hFFFF, 1'b0, 16'hBFFE, 1'b1);
    add("cichain",16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    add("cionly", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    add("zero",   16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    add("grpmid", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) check($sformatf("b2b%0d", i - 1), bb_s[i-1], bb_co[i-1]);
      rst = (i == 4);
      in1 = bb_a[i]; in2 = bb_b[i]; carry_in = bb_ci[i];
    end
    @(negedge clk);
    check("b2b7", bb_s[7], bb_co[7]);
    rst = 1'b0;

    for (int i = 0; i < 10000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [16:0] r;
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      r  = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
      add("rand", a, b, ci, r[15:0], r[16]);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
